// File: rtl/exec_mem_unit_if.sv
// Handshake, result and SRAM bus of the execute/memory backend.
// Master is the operand-fetch/SRAM side, slave is the backend itself.
interface exec_mem_unit_if #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_op;
  logic [4:0]        mem_op;
  logic [XLEN-1:0]   operand_a;
  logic [XLEN-1:0]   operand_b;
  logic [XLEN-1:0]   store_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic              out_wb;
  logic              out_err;
  logic              mem_en;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output in_valid, alu_op, mem_op, operand_a, operand_b, store_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, out_wb, out_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, alu_op, mem_op, operand_a, operand_b, store_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, out_wb, out_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/exec_mem_unit.sv
// Execute/memory backend: ALU, stepped barrel shifter and byte-lane load/store unit.
// States: IDLE waiting | SHIFT remaining shift steps | MEM one SRAM cycle | DONE result held
module exec_mem_unit #(
  parameter int XLEN       = 32,
  parameter int MEM_AW     = 16,
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_mem_unit_if.slave  bus
);
  localparam int NB    = XLEN / 8;
  localparam int ALIGN = $clog2(NB);
  localparam int SHW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, MEM, DONE} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   shv_q;
  logic [SHW-1:0]    rem_q;
  logic [3:0]        op_q;
  logic [ALIGN-1:0]  lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              is_load_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_data_q;
  logic              out_wb_q;
  logic              out_err_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [NB-1:0]     mem_be_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;

  logic              in_ready;
  logic              accept;

  function automatic logic [SHW-1:0] step_of(input logic [SHW-1:0] rem);
    return (rem > SHW'(SHIFT_STEP)) ? SHW'(SHIFT_STEP) : rem;
  endfunction

  // SRA fills from the current MSB, which stays equal to the original sign bit.
  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [3:0]      op,
                                               input logic [SHW-1:0]  amt);
    logic [XLEN-1:0] r;
    case (op)
      4'd8:    r = v << amt;
      4'd9:    r = v >> amt;
      default: r = $signed(v) >>> amt;
    endcase
    return r;
  endfunction

  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  logic [XLEN-1:0]  ea_d;
  logic [XLEN-1:0]  alu_res_d;
  logic [XLEN-1:0]  wdata_d;
  logic [SHW-1:0]   shamt_d;
  logic [ALIGN-1:0] lane_d;
  logic [NB-1:0]    size_mask_d;
  logic [NB-1:0]    be_d;
  logic             is_ld_d;
  logic             is_st_d;
  logic             is_sh_d;
  logic             mis_d;

  always_comb begin
    ea_d    = bus.operand_a + bus.operand_b;
    lane_d  = ea_d[ALIGN-1:0];
    shamt_d = bus.operand_b[SHW-1:0];
    is_ld_d = bus.mem_op[3];
    is_st_d = bus.mem_op[2] & ~bus.mem_op[3];
    is_sh_d = ~is_ld_d & ~is_st_d & (bus.alu_op inside {4'd8, 4'd9, 4'd10}) & (shamt_d != '0);

    case (bus.mem_op[1:0])
      2'd0:    begin mis_d = 1'b0;                        size_mask_d = NB'(1);  end
      2'd1:    begin mis_d = lane_d[0];                   size_mask_d = NB'(3);  end
      2'd2:    begin mis_d = (lane_d[1:0] != 2'd0);       size_mask_d = NB'(15); end
      default: begin mis_d = (XLEN == 32) || (lane_d != '0); size_mask_d = '1;   end
    endcase
    be_d = size_mask_d << lane_d;

    case (bus.mem_op[1:0])
      2'd0:    wdata_d = {NB{bus.store_data[7:0]}};
      2'd1:    wdata_d = {(NB/2){bus.store_data[15:0]}};
      2'd2:    wdata_d = {(NB/4){bus.store_data[31:0]}};
      default: wdata_d = bus.store_data;
    endcase

    case (bus.alu_op)
      4'd0:    alu_res_d = bus.operand_a + bus.operand_b;
      4'd1:    alu_res_d = bus.operand_a - bus.operand_b;
      4'd2:    alu_res_d = bus.operand_a & bus.operand_b;
      4'd3:    alu_res_d = bus.operand_a | bus.operand_b;
      4'd4:    alu_res_d = bus.operand_a ^ bus.operand_b;
      4'd5:    alu_res_d = XLEN'($signed(bus.operand_a) < $signed(bus.operand_b));
      4'd6:    alu_res_d = XLEN'(bus.operand_a < bus.operand_b);
      4'd7:    alu_res_d = bus.operand_b;
      4'd8, 4'd9, 4'd10:
               alu_res_d = shift_by(bus.operand_a, bus.alu_op, step_of(shamt_d));
      default: alu_res_d = '0;
    endcase
  end

  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_mask;
  logic [XLEN-1:0] ld_ext;
  logic            ld_sign;

  always_comb begin
    ld_shift = bus.mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_shift[7];      end
      2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_shift[15];     end
      2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31];     end
      default: begin ld_mask = '1;                   ld_sign = ld_shift[XLEN-1]; end
    endcase
    ld_ext = (ld_shift & ld_mask) | ((~uns_q & ld_sign) ? ~ld_mask : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shv_q       <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      is_load_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_wb_q    <= 1'b0;
      out_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        SHIFT: begin
          shv_q <= shift_by(shv_q, op_q, step_of(rem_q));
          rem_q <= rem_q - step_of(rem_q);
          if (rem_q <= SHW'(SHIFT_STEP)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= shift_by(shv_q, op_q, step_of(rem_q));
          end
        end
        // Read data is taken at the close of the single enabled SRAM cycle.
        MEM: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          if (is_load_q) out_data_q <= ld_ext;
        end
        DONE: begin
          if (bus.out_ready && !bus.in_valid) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        op_q      <= bus.alu_op;
        lane_q    <= lane_d;
        size_q    <= bus.mem_op[1:0];
        uns_q     <= bus.mem_op[4];
        is_load_q <= is_ld_d;
        out_err_q <= 1'b0;
        out_wb_q  <= 1'b1;
        if (is_ld_d || is_st_d) begin
          if (mis_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_wb_q    <= 1'b0;
            out_data_q  <= ea_d;
          end else begin
            state_q     <= MEM;
            out_valid_q <= 1'b0;
            out_wb_q    <= is_ld_d;
            out_data_q  <= '0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= is_st_d;
            mem_addr_q  <= ea_d[MEM_AW+ALIGN-1:ALIGN];
            mem_be_q    <= is_st_d ? be_d : '0;
            if (is_st_d) mem_wdata_q <= wdata_d;
          end
        end else begin
          shv_q <= alu_res_d;
          rem_q <= shamt_d - step_of(shamt_d);
          if (is_sh_d && (shamt_d > SHW'(SHIFT_STEP))) begin
            state_q     <= SHIFT;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= alu_res_d;
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_wb    = out_wb_q;
  assign bus.out_err   = out_err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized bench for exec_mem_unit against a behavioural operation model.
// The bench plays both operand source and SRAM (read data held stable per op).
module tb_exec_mem_unit;
  localparam int XLEN   = 32;
  localparam int MEM_AW = 16;
  localparam int STEP   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_mem_unit_if #(.XLEN(XLEN), .MEM_AW(MEM_AW)) bus ();

  exec_mem_unit #(.XLEN(XLEN), .MEM_AW(MEM_AW), .SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic model(input logic [3:0] op, input logic [4:0] mop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [31:0] rd,
                       output logic [31:0] d, output logic wb, output logic err,
                       output logic we, output int lat, output int nmem,
                       output logic [3:0] be, output logic [15:0] addr,
                       output logic [31:0] wd);
    logic [31:0] ea;
    int nbytes, lane, sh;
    longint unsigned msk, v;
    d = '0; wb = 1'b1; err = 1'b0; we = 1'b0; lat = 1; nmem = 0;
    be = '0; addr = '0; wd = '0;
    ea = a + b;
    nbytes = 1 << mop[1:0];
    lane = int'(ea % 4);
    if (mop[3] || mop[2]) begin
      if (mop[1:0] == 2'd3 || (ea % nbytes) != 0) begin
        err = 1'b1; wb = 1'b0; d = ea;
      end else begin
        lat = 2; nmem = 1; addr = 16'(ea / 4);
        if (!mop[3]) begin
          we = 1'b1; wb = 1'b0;
          be = 4'(((1 << nbytes) - 1) << lane);
          for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nbytes) +: 8];
        end else begin
          msk = (64'd1 << (8 * nbytes)) - 64'd1;
          v = (64'(rd) >> (8 * lane)) & msk;
          if (!mop[4] && v[8*nbytes-1]) v = v | ~msk;
          d = 32'(v);
        end
      end
    end else begin
      sh = int'(b[4:0]);
      case (op)
        4'd0:    d = a + b;
        4'd1:    d = a - b;
        4'd2:    d = a & b;
        4'd3:    d = a | b;
        4'd4:    d = a ^ b;
        4'd5:    d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd6:    d = (a < b) ? 32'd1 : 32'd0;
        4'd7:    d = b;
        4'd8:    d = a << sh;
        4'd9:    d = a >> sh;
        4'd10:   d = $signed(a) >>> sh;
        default: d = '0;
      endcase
      if (op >= 4'd8 && op <= 4'd10 && sh > 0) lat = (sh + STEP - 1) / STEP;
    end
  endtask

  // Issues one op (from IDLE, or back-to-back from DONE) and checks it; leaves the result held.
  task automatic do_op(input logic [3:0] op, input logic [4:0] mop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [31:0] rd, input int hold);
    logic [31:0] e_d, e_wd;
    logic e_wb, e_err, e_we;
    int e_lat, e_nmem, cyc, nmem;
    logic [3:0] e_be;
    logic [15:0] e_addr;
    model(op, mop, a, b, sd, rd, e_d, e_wb, e_err, e_we, e_lat, e_nmem, e_be, e_addr, e_wd);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.mem_op = mop;
    bus.operand_a = a; bus.operand_b = b; bus.store_data = sd;
    bus.mem_rdata = rd; bus.out_ready = 1'b1;
    #1 check("accept_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_op = 4'($urandom); bus.mem_op = 5'($urandom);
    bus.operand_a = $urandom; bus.operand_b = $urandom; bus.store_data = $urandom;
    cyc = 1; nmem = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      check("busy_rdy", bus.in_ready, 0);
      if (bus.mem_en === 1'b1) begin
        nmem++;
        check("mem_we", bus.mem_we, e_we);
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_be", bus.mem_be, e_be);
        if (e_we) check("mem_wdata", bus.mem_wdata, e_wd);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, e_lat);
    check("mem_cycles", nmem, e_nmem);
    check("mem_en_off", bus.mem_en, 0);
    check("out_data", bus.out_data, e_d);
    check("out_wb", bus.out_wb, e_wb);
    check("out_err", bus.out_err, e_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, e_d);
      check("hold_wb", bus.out_wb, e_wb);
      check("hold_rdy", bus.in_ready, 0);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", bus.out_valid, 0);
    check("drain_rdy", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  logic [3:0]  r_op;
  logic [4:0]  r_mop;
  logic [31:0] r_a, r_b, r_sd, r_rd;

  initial begin
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.mem_op = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.store_data = '0;
    bus.out_ready = 1'b0; bus.mem_rdata = '0;
    #12;
    check("rst_rdy", bus.in_ready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_be", bus.mem_be, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", bus.in_ready, 1);

    do_op(4'd0, 5'b00000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);
    drain();
    do_op(4'd10, 5'b00000, 32'h8000_0000, 32'd20, 32'd0, 32'd0, 0);
    check("sra20_const", bus.out_data, 32'hFFFF_F800);
    do_op(4'd0, 5'b00100, 32'h100, 32'd3, 32'hAB, 32'd0, 0);
    do_op(4'd0, 5'b01000, 32'h100, 32'd3, 32'd0, 32'hAB00_0000, 0);
    check("ldb_signed_const", bus.out_data, 32'hFFFF_FFAB);
    do_op(4'd0, 5'b11000, 32'h100, 32'd3, 32'd0, 32'hAB00_0000, 0);
    check("ldb_unsigned_const", bus.out_data, 32'h0000_00AB);
    do_op(4'd0, 5'b01010, 32'h100, 32'd2, 32'd0, 32'h1234_5678, 5);
    check("ldw_mis_const", bus.out_data, 32'h102);
    do_op(4'd9, 5'b00000, 32'hF000_000F, 32'd8, 32'd0, 32'd0, 0);
    do_op(4'd8, 5'b00000, 32'h0000_0001, 32'd31, 32'd0, 32'd0, 1);
    do_op(4'd0, 5'b00111, 32'h100, 32'd0, 32'd0, 32'd0, 0);
    drain();

    // Reset while a load sits in its SRAM cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = 4'd0; bus.mem_op = 5'b01010;
    bus.operand_a = 32'h200; bus.operand_b = 32'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rst_mid_mem_en", bus.mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_off", bus.mem_en, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_rdy", bus.in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_rdy", bus.in_ready, 1);
    check("rst_rel_valid", bus.out_valid, 0);
    check("rst_rel_mem_en", bus.mem_en, 0);

    for (int i = 0; i < 200; i++) begin
      r_op = 4'($urandom); r_a = $urandom; r_b = $urandom;
      r_sd = $urandom; r_rd = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        r_mop = {1'($urandom), 2'b00, 2'($urandom)};
      end else begin
        r_mop = {1'($urandom), 2'($urandom_range(1, 3)), 2'($urandom)};
        r_b = $urandom_range(0, 1023);
        if ($urandom_range(0, 1) == 1) r_b = r_b - ((r_a + r_b) & 32'h7);
      end
      do_op(r_op, r_mop, r_a, r_b, r_sd, r_rd, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
